// File: rtl/traffic_pkg.sv
// Shared types and default timing constants for the traffic-light controller
// and its upstream interval timer / car-sensor front end.
package traffic_pkg;

  typedef enum logic [1:0] {
    ABSENT      = 2'd0,
    CONFIRM_ON  = 2'd1,
    PRESENT     = 2'd2,
    CONFIRM_OFF = 2'd3
  } deb_state_t;

  localparam int unsigned DEF_SHORT_CYCLES = 5;
  localparam int unsigned DEF_LONG_CYCLES  = 25;
  localparam int unsigned DEF_DEB_CYCLES   = 3;
  localparam int unsigned DEF_CNT_W        = 8;

endpackage

// File: rtl/car_debounce.sv
// Two-flop synchroniser followed by a debounce FSM that only moves C after
// DEB_CYCLES consecutive agreeing synchronised samples.
module car_debounce
  import traffic_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic R,
  input  logic car_raw,
  output logic C
);

  localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

  logic          sync1;
  logic          cs;
  deb_state_t    state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          c_d;
  logic          last_sample;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the sync chain into one flop.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      sync1   <= 1'b0;
      cs      <= 1'b0;
      state_q <= ABSENT;
      dcnt_q  <= '0;
      C       <= 1'b0;
    end else begin
      sync1   <= car_raw;
      cs      <= sync1;
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      C       <= c_d;
    end
  end

  assign last_sample = ((int'(dcnt_q) + 1) == int'(DEB_CYCLES));

  // NOTE: every output of this block is defaulted first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      ABSENT: begin
        if (cs) begin
          if (DEB_CYCLES == 1) begin
            state_d = PRESENT;
            dcnt_d  = '0;
          end else begin
            state_d = CONFIRM_ON;
            dcnt_d  = DW'(1);
          end
        end
      end
      CONFIRM_ON: begin
        if (!cs) begin
          state_d = ABSENT;
          dcnt_d  = '0;
        end else if (last_sample) begin
          state_d = PRESENT;
          dcnt_d  = '0;
        end else begin
          dcnt_d  = dcnt_q + 1'b1;
        end
      end
      PRESENT: begin
        if (!cs) begin
          if (DEB_CYCLES == 1) begin
            state_d = ABSENT;
            dcnt_d  = '0;
          end else begin
            state_d = CONFIRM_OFF;
            dcnt_d  = DW'(1);
          end
        end
      end
      CONFIRM_OFF: begin
        if (cs) begin
          state_d = PRESENT;
          dcnt_d  = '0;
        end else if (last_sample) begin
          state_d = ABSENT;
          dcnt_d  = '0;
        end else begin
          dcnt_d  = dcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ABSENT;
        dcnt_d  = '0;
      end
    endcase
    // C reflects the committed level; the CONFIRM states keep the old one.
    c_d = (state_d == PRESENT) || (state_d == CONFIRM_OFF);
  end

endmodule

// File: rtl/traffic_interval_timer.sv
// Phase-interval counter with short/long expiry flags, plus the debounced
// east-road car sensor, feeding the traffic-light controller.
module traffic_interval_timer
  import traffic_pkg::*;
#(
  parameter int unsigned SHORT_CYCLES = DEF_SHORT_CYCLES,
  parameter int unsigned LONG_CYCLES  = DEF_LONG_CYCLES,
  parameter int unsigned DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             R,
  input  logic             IC,
  input  logic             car_raw,
  output logic             S,
  output logic             L,
  output logic             C,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] SHORT_C = CNT_W'(SHORT_CYCLES);
  localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_CYCLES);

  // Clear wins over counting; the count parks at LONG_C instead of wrapping.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      cnt <= '0;
    end else if (IC) begin
      cnt <= '0;
    end else if (cnt < LONG_C) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign S = (cnt >= SHORT_C);
  assign L = (cnt >= LONG_C);

  car_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_car_debounce (
    .clk     (clk),
    .R       (R),
    .car_raw (car_raw),
    .C       (C)
  );

endmodule

// File: tb/tb_traffic_interval_timer.sv
// Directed bench for traffic_interval_timer: default instance plus a
// SHORT=1/LONG=2/DEB=1 instance, compared cycle by cycle against a scoreboard.
module tb_traffic_interval_timer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         R   = 1'b0;
  logic         IC  = 1'b0;
  logic         car_raw = 1'b0;
  logic         S, L, C;
  logic [W-1:0] cnt;
  logic         ic2 = 1'b0;
  logic         car2 = 1'b0;
  logic         s2, l2, c2;
  logic [W-1:0] cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  traffic_interval_timer dut (
    .clk(clk), .R(R), .IC(IC), .car_raw(car_raw),
    .S(S), .L(L), .C(C), .cnt(cnt)
  );

  traffic_interval_timer #(
    .SHORT_CYCLES(1), .LONG_CYCLES(2), .DEB_CYCLES(1), .CNT_W(W)
  ) dut2 (
    .clk(clk), .R(R), .IC(ic2), .car_raw(car2),
    .S(s2), .L(l2), .C(c2), .cnt(cnt2)
  );

  // Reference model: edges since the last clear, and a window of
  // synchronised samples; C takes value v once the last DEB samples are all v.
  typedef struct packed {
    int       since;
    bit       s1;
    bit       cs;
    bit [7:0] hist;
    int       valid;
    bit       c;
  } model_t;

  typedef struct packed {
    int cnt;
    bit s;
    bit l;
    bit c;
  } exp_t;

  model_t m1, m2;
  exp_t   sb1[$];
  exp_t   sb2[$];

  function automatic model_t model_reset();
    model_t m;
    m = '0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, bit ic, bit raw, int deb);
    bit [7:0] mask;
    mask = 8'((1 << deb) - 1);
    m.hist = {m.hist[6:0], m.cs};
    if (m.valid < 8) m.valid++;
    if (m.valid >= deb) begin
      if ((m.hist & mask) == mask) m.c = 1'b1;
      else if ((m.hist & mask) == 8'd0) m.c = 1'b0;
    end
    m.cs = m.s1;
    m.s1 = raw;
    if (ic) m.since = 0;
    else if (m.since < 1000) m.since++;
    return m;
  endfunction

  function automatic exp_t expect_of(model_t m, int sh, int lg);
    exp_t e;
    e.cnt = (m.since > lg) ? lg : m.since;
    e.s   = (e.cnt >= sh);
    e.l   = (e.cnt >= lg);
    e.c   = m.c;
    return e;
  endfunction

  task automatic check(input string tag, input int obs, input int exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Push the expectation for the coming edge, clock it, pop and compare.
  task automatic cycle(input string tag);
    exp_t e1, e2;
    m1 = model_step(m1, IC, car_raw, 3);
    m2 = model_step(m2, ic2, car2, 1);
    sb1.push_back(expect_of(m1, 5, 25));
    sb2.push_back(expect_of(m2, 1, 2));
    @(posedge clk);
    #1;
    e1 = sb1.pop_front();
    e2 = sb2.pop_front();
    check({tag, ".cnt"}, int'(cnt), e1.cnt);
    check({tag, ".S"},   int'(S),   int'(e1.s));
    check({tag, ".L"},   int'(L),   int'(e1.l));
    check({tag, ".C"},   int'(C),   int'(e1.c));
    check({tag, ".cnt2"}, int'(cnt2), e2.cnt);
    check({tag, ".S2"},   int'(s2),   int'(e2.s));
    check({tag, ".L2"},   int'(l2),   int'(e2.l));
    check({tag, ".C2"},   int'(c2),   int'(e2.c));
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic drive(input bit ic, input bit raw);
    IC = ic; ic2 = ic; car_raw = raw; car2 = raw;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".cnt"}, int'(cnt), 0);
    check({tag, ".S"},   int'(S),   0);
    check({tag, ".L"},   int'(L),   0);
    check({tag, ".C"},   int'(C),   0);
    check({tag, ".cnt2"}, int'(cnt2), 0);
    check({tag, ".C2"},   int'(c2),   0);
  endtask

  initial begin
    m1 = model_reset();
    m2 = model_reset();
    #12;
    check_zero("por");
    @(negedge clk);
    R = 1'b1;

    // Interval from a single-cycle clear; car arrives partway and stays.
    drive(1'b1, 1'b0); cycle("ic_pulse");
    drive(1'b0, 1'b0); run("count", 3);
    drive(1'b0, 1'b1); run("count_car", 33);
    check("sat_cnt", int'(cnt), 25);

    // Clear on the saturated edge, then clear held for 8 cycles.
    drive(1'b1, 1'b1); cycle("restart");
    check("restart_cnt", int'(cnt), 0);
    run("ic_hold", 7);
    drive(1'b0, 1'b1); run("recount", 4);

    // Car leaves: C falls DEB+1 edges after the sampled change.
    drive(1'b0, 1'b0); run("release", 8);
    check("released_C", int'(C), 0);

    // Glitches against C=0: one 2-cycle pulse, then 1-cycle pulses.
    drive(1'b0, 1'b1); run("g0_pulse2", 2);
    drive(1'b0, 1'b0); run("g0_gap", 4);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1); cycle("g0_pulse1");
      drive(1'b0, 1'b0); run("g0_gap1", 3);
    end
    check("g0_C", int'(C), 0);

    // Establish C=1, then glitch low.
    drive(1'b0, 1'b1); run("accept", 6);
    check("accept_C", int'(C), 1);
    drive(1'b0, 1'b0); run("g1_pulse2", 2);
    drive(1'b0, 1'b1); run("g1_gap", 4);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0); cycle("g1_pulse1");
      drive(1'b0, 1'b1); run("g1_gap1", 3);
    end
    check("g1_C", int'(C), 1);

    // Asynchronous reset at cnt=12 with C=1, between clock edges.
    drive(1'b1, 1'b1); cycle("pre_rst_ic");
    drive(1'b0, 1'b1); run("pre_rst", 12);
    check("pre_rst_cnt", int'(cnt), 12);
    #2;
    R = 1'b0;
    #1;
    check_zero("async_rst");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_zero("rst_held");
    end
    m1 = model_reset();
    m2 = model_reset();
    @(negedge clk);
    R = 1'b1;
    drive(1'b0, 1'b0); run("post_rst", 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/traffic_interval_timer.md
Name: traffic_interval_timer

Overview:
- Upstream stage of the traffic-light controller; produces its S, L and C inputs and consumes its IC (interval clear) output.
- Holds one phase-interval counter, restarted by IC, that flags short-interval expiry (S) and long-interval expiry (L).
- Also synchronises and debounces the raw east-road car sensor into a clean car-present level (C).

Parameters:
- SHORT_CYCLES, 5, cycles after IC until S asserts (yellow/min-green time).
- LONG_CYCLES, 25, cycles after IC until L asserts (max-green time). Must satisfy SHORT_CYCLES < LONG_CYCLES < 2**CNT_W.
- DEB_CYCLES, 3, consecutive agreeing synchronised samples required to change C (>=1).
- CNT_W, 8, width of the interval counter.

Ports:
- clk  in  1  system clock, rising-edge.
- R  in  1  reset; asynchronous, active-low (R=0 resets).
- IC  in  1  interval clear from controller, synchronous, level-sampled.
- car_raw  in  1  raw car sensor, asynchronous to clk, may bounce.
- S  out  1  short interval expired.
- L  out  1  long interval expired.
- C  out  1  debounced car present.
- cnt  out  CNT_W  current interval count, for debug/observation.

Behaviour:
- Reset (R=0, any time, no clock needed): cnt=0, S=0, L=0, C=0, sync flops=0, debounce state ABSENT, debounce count=0. Reset mid-interval or mid-debounce discards all progress.
- Interval counter, per rising edge:
  - IC=1: cnt <= 0.
  - Else if cnt < LONG_CYCLES: cnt <= cnt+1.
  - Else cnt holds at LONG_CYCLES (saturation, no wrap).
  - IC has priority over increment and saturation.
- S = (cnt >= SHORT_CYCLES) and L = (cnt >= LONG_CYCLES), decoded from the registered cnt; no extra latency.
- Timing relative to IC: with IC high at edge t and low afterwards, S goes high after edge t+SHORT_CYCLES and L after edge t+LONG_CYCLES.
  - S and L fall after the first edge where IC=1.
  - If IC is held high, cnt stays 0 and S=L=0.
- Car sensor path:
  - car_raw passes through two flops (sync1 -> cs).
  - Debounce FSM (dcnt counts consecutive agreeing samples):
    - ABSENT (C=0): cs=1 -> CONFIRM_ON, dcnt=1.
    - CONFIRM_ON (C=0): cs=0 -> ABSENT, dcnt=0. cs=1 and dcnt+1==DEB_CYCLES -> PRESENT, C=1, dcnt=0. Otherwise dcnt++.
    - PRESENT (C=1): cs=0 -> CONFIRM_OFF, dcnt=1.
    - CONFIRM_OFF (C=1): cs=1 -> PRESENT, dcnt=0. cs=0 and dcnt+1==DEB_CYCLES -> ABSENT, C=0. Otherwise dcnt++.
  - When DEB_CYCLES=1, the transition out of ABSENT/PRESENT goes directly to PRESENT/ABSENT, toggling C, skipping the CONFIRM state.
  - C is registered.
  - Latency: a stable change of car_raw sampled at edge t changes C after edge t+1+DEB_CYCLES.
  - A pulse shorter than DEB_CYCLES samples never changes C.
- The interval counter and debouncer are independent; simultaneous IC and a sensor change have no interaction.

Decomposition:
- Shared package traffic_pkg:
  - debounce state enum {ABSENT, CONFIRM_ON, PRESENT, CONFIRM_OFF}.
  - Default SHORT_CYCLES / LONG_CYCLES / DEB_CYCLES constants.
  - The controller also uses these constants.
- One natural sub-module: car_debounce (synchroniser + FSM, parameter DEB_CYCLES, ports clk, R, car_raw, C).
- Interval counter and S/L decode stay in the top.

Test Plan:
- Reset: drive R=0 mid-count (cnt=12) and with C=1 -> cnt=0, S=L=C=0 immediately, without a clock edge; they stay 0 until R=1.
- Interval: pulse IC for 1 cycle, then hold low -> S rises after the 5th following edge, L after the 25th; cnt saturates at 25 for 10 more cycles, S=L=1 steady.
- Restart priority: IC=1 on the edge where cnt=25 -> cnt=0, S=L=0 next cycle. IC held high 8 cycles -> cnt stays 0.
- Debounce accept: car_raw 0->1 held 10 cycles -> C=1 after edge t+4 (DEB_CYCLES=3). Release, hold 0 -> C=0 after edge t'+4.
- Glitch reject: with C=0, car_raw pulses high for 2 cycles, then repeats 1-cycle pulses -> C stays 0 and the FSM returns to ABSENT each time. Same glitches with C=1 -> C stays 1.
- Parameter sweep: SHORT=1, LONG=2, DEB=1 -> S after edge t+1, L after edge t+2; C follows cs with 1-edge delay.
